hazard_ctrl_mc: RTL and testbench
=================================

Name: hazard_ctrl_mc

Overview:
Parametrised successor to the pipeline hazard detector for the 5-stage RISC-V core. It sits beside the F_D, D_E and E_M pipeline registers and drives their flush and stall controls.
- Adds multi-cycle load-use stalls for slower data memories.
- Adds a multi-cycle execute (mul/div) busy window.
- Adds x0 and operand-use qualification of dependencies.
- Adds saturating performance counters for stall and flush cycles.

Parameters:
REG_IDX_W, 5, register index width
LOAD_USE_STALL, 1, bubble cycles inserted per load-use hazard (1..15)
MULDIV_LAT, 4, execute latency of mul/div in cycles (1..16); stall cycles = MULDIV_LAT-1
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
F_D_rs1_index  in  REG_IDX_W  rs1 of instruction in decode
F_D_rs2_index  in  REG_IDX_W  rs2 of instruction in decode
F_D_rs1_used  in  1  decode instruction reads rs1
F_D_rs2_used  in  1  decode instruction reads rs2
D_E_wb_sel  in  1  instruction in execute is a load
D_E_rd_index  in  REG_IDX_W  rd of instruction in execute
D_E_is_muldiv  in  1  instruction in execute is mul/div
E_M_is_jalr  in  1  jalr resolved in E_M
E_M_hit  in  1  branch prediction correct (0 = mispredict)
F_D_flush  out  1  flush F_D register
D_E_flush  out  1  flush D_E register (insert bubble)
E_M_flush  out  1  flush E_M register (insert bubble)
PC_stall  out  1  hold PC
F_D_stall  out  1  hold F_D register
D_E_stall  out  1  hold D_E register
md_busy  out  1  mul/div stall window active
stall_cycle_cnt  out  CNT_W  cycles with PC_stall=1, saturating
flush_cnt  out  CNT_W  redirect cycles, saturating

Behaviour:
- redirect = !E_M_hit | E_M_is_jalr.
- lu_hit = D_E_wb_sel & (D_E_rd_index != 0) & ((F_D_rs1_used & rs1 == rd) | (F_D_rs2_used & rs2 == rd)).
- md_hit = D_E_is_muldiv & (MULDIV_LAT > 1). If D_E_wb_sel and D_E_is_muldiv are both 1, md_hit wins.
- FSM states: IDLE, LU_STALL, MD_BUSY. Counter cnt is 4 bits.
- Outputs are combinational from state and inputs.
- Priority per cycle: redirect > MD_BUSY/md_hit > LU_STALL/lu_hit.
- Redirect, any state:
  - F_D_flush = D_E_flush = E_M_flush = 1; all stalls 0.
  - next state IDLE, cnt = 0, flush_cnt += 1.
  - Pending load or mul/div stall is abandoned.
- IDLE, md_hit:
  - PC_stall = F_D_stall = D_E_stall = 1, E_M_flush = 1, md_busy = 1.
  - If MULDIV_LAT == 2, stay IDLE; else go to MD_BUSY with cnt = MULDIV_LAT-3.
- MD_BUSY:
  - Same outputs as IDLE/md_hit.
  - cnt == 0 -> IDLE; else cnt -= 1.
  - D_E_is_muldiv and lu_hit inputs are ignored in this state.
- IDLE, lu_hit (no md_hit):
  - PC_stall = F_D_stall = D_E_flush = 1.
  - If LOAD_USE_STALL == 1, stay IDLE; else go to LU_STALL with cnt = LOAD_USE_STALL-2.
- LU_STALL:
  - PC_stall = F_D_stall = D_E_flush = 1.
  - cnt == 0 -> IDLE; else cnt -= 1.
  - New lu_hit is ignored here: D_E already holds a bubble.
- IDLE, no hazard: all outputs 0.
- Latency: stall and flush outputs respond in the same cycle as the triggering input (zero latency). Bubble counts are exact:
  - LOAD_USE_STALL cycles per load-use hazard.
  - MULDIV_LAT-1 cycles per mul/div.
- Counters:
  - stall_cycle_cnt += 1 on every cycle where PC_stall = 1.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- Reset, when rst_n = 0 at a rising edge:
  - state IDLE, cnt 0, both counters 0.
  - Reset mid-stall aborts the stall.
  - While rst_n = 0, all flush and stall outputs and md_busy are forced to 0.
- x0: rd = 0 never triggers a load-use hazard. A disabled operand (used = 0) never matches.

Test Plan:
1. LOAD_USE_STALL=1: D_E_wb_sel=1, rd=5, rs1=5, used=1 for one cycle -> PC_stall/F_D_stall/D_E_flush=1 for exactly 1 cycle; stall_cycle_cnt=1.
2. LOAD_USE_STALL=3: same hazard -> stall outputs high for 3 consecutive cycles, then 0. A redirect in the 2nd cycle -> all three flushes=1, stalls=0, state IDLE, flush_cnt=1.
3. rd=0 with rs1=0, and rd=7 with rs2=7 but rs2_used=0 -> no stall in either case; counters stay 0.
4. MULDIV_LAT=4: D_E_is_muldiv=1 -> md_busy, PC/F_D/D_E stall and E_M_flush high for exactly 3 cycles. MULDIV_LAT=1 -> no stall.
5. E_M_hit=0 and lu_hit in the same cycle -> flushes all 1, PC_stall=0. Next cycle with no hazard -> all outputs 0.
6. CNT_W=4: hold a hazard 20 cycles -> stall_cycle_cnt sticks at 15. rst_n=0 in the middle of an MD_BUSY window -> counters 0, outputs 0, state IDLE next cycle.

Source files
------------

// File: rtl/hazard_ctrl_mc_if.sv
// hazard_ctrl_mc_if: pipeline-register hazard inputs and flush/stall/counter outputs
interface hazard_ctrl_mc_if #(
  parameter int REG_IDX_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_IDX_W-1:0] F_D_rs1_index, F_D_rs2_index, D_E_rd_index;
  logic F_D_rs1_used, F_D_rs2_used, D_E_wb_sel, D_E_is_muldiv, E_M_is_jalr, E_M_hit;
  logic F_D_flush, D_E_flush, E_M_flush, PC_stall, F_D_stall, D_E_stall, md_busy;
  logic [CNT_W-1:0] stall_cycle_cnt, flush_cnt;
  modport master (
    output F_D_rs1_index, F_D_rs2_index, F_D_rs1_used, F_D_rs2_used, D_E_wb_sel, D_E_rd_index,
           D_E_is_muldiv, E_M_is_jalr, E_M_hit,
    input  F_D_flush, D_E_flush, E_M_flush, PC_stall, F_D_stall, D_E_stall, md_busy,
           stall_cycle_cnt, flush_cnt
  );
  modport slave (
    input  F_D_rs1_index, F_D_rs2_index, F_D_rs1_used, F_D_rs2_used, D_E_wb_sel, D_E_rd_index,
           D_E_is_muldiv, E_M_is_jalr, E_M_hit,
    output F_D_flush, D_E_flush, E_M_flush, PC_stall, F_D_stall, D_E_stall, md_busy,
           stall_cycle_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: load-use / mul-div / redirect hazard control with saturating perf counters
module hazard_ctrl_mc #(
  parameter int REG_IDX_W = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_ctrl_mc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LU_STALL, MD_BUSY} state_t;
  localparam logic [3:0] MD_INIT = MULDIV_LAT > 2 ? 4'(MULDIV_LAT - 3) : 4'd0;
  localparam logic [3:0] LU_INIT = LOAD_USE_STALL > 1 ? 4'(LOAD_USE_STALL - 2) : 4'd0;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic redirect, lu_hit, md_hit, in_md, in_lu, md_act, lu_act;
  always_comb begin
    redirect = !bus.E_M_hit | bus.E_M_is_jalr;
    lu_hit = bus.D_E_wb_sel && (bus.D_E_rd_index != '0) &&
             ((bus.F_D_rs1_used && bus.F_D_rs1_index == bus.D_E_rd_index) ||
              (bus.F_D_rs2_used && bus.F_D_rs2_index == bus.D_E_rd_index));
    md_hit = bus.D_E_is_muldiv && (MULDIV_LAT > 1);
    in_md = state == MD_BUSY;
    in_lu = state == LU_STALL;
    md_act = !redirect && (in_md || md_hit);
    lu_act = !redirect && !md_act && (in_lu || lu_hit);
    state_nx = IDLE;
    cnt_nx = '0;
    if (md_act && in_md && cnt != 0) begin
      state_nx = MD_BUSY;
      cnt_nx = cnt - 1'b1;
    end else if (md_act && !in_md && MULDIV_LAT > 2) begin
      state_nx = MD_BUSY;
      cnt_nx = MD_INIT;
    end else if (lu_act && in_lu && cnt != 0) begin
      state_nx = LU_STALL;
      cnt_nx = cnt - 1'b1;
    end else if (lu_act && !in_lu && LOAD_USE_STALL > 1) begin
      state_nx = LU_STALL;
      cnt_nx = LU_INIT;
    end
  end
  assign bus.F_D_flush = rst_n & redirect;
  assign bus.D_E_flush = rst_n & (redirect | lu_act);
  assign bus.E_M_flush = rst_n & (redirect | md_act);
  assign bus.PC_stall = rst_n & (md_act | lu_act);
  assign bus.F_D_stall = rst_n & (md_act | lu_act);
  assign bus.D_E_stall = rst_n & md_act;
  assign bus.md_busy = rst_n & md_act;
  assign bus.stall_cycle_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if ((md_act | lu_act) && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      if (redirect && ~&flush_cnt) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: directed checks of two hazard_ctrl_mc configurations driven in lockstep
module tb_hazard_ctrl_mc;
  logic clk = 0;
  logic rst_n = 0;
  int vec = 0;
  int err = 0;
  always #5 clk = ~clk;
  hazard_ctrl_mc_if #(.REG_IDX_W(5), .CNT_W(16)) ia ();
  hazard_ctrl_mc_if #(.REG_IDX_W(5), .CNT_W(4)) ib ();
  hazard_ctrl_mc #(.REG_IDX_W(5), .LOAD_USE_STALL(1), .MULDIV_LAT(4), .CNT_W(16)) ua (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );
  hazard_ctrl_mc #(.REG_IDX_W(5), .LOAD_USE_STALL(3), .MULDIV_LAT(1), .CNT_W(4)) ub (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );
  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_LU = 7'b0101100;
  localparam logic [6:0] O_MD = 7'b0011111;
  localparam logic [6:0] O_RD = 7'b1110000;
  function automatic logic [6:0] oa();
    return {ia.F_D_flush, ia.D_E_flush, ia.E_M_flush, ia.PC_stall, ia.F_D_stall, ia.D_E_stall, ia.md_busy};
  endfunction
  function automatic logic [6:0] ob();
    return {ib.F_D_flush, ib.D_E_flush, ib.E_M_flush, ib.PC_stall, ib.F_D_stall, ib.D_E_stall, ib.md_busy};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input logic wb, input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic md, input logic jalr,
                        input logic hit);
    ia.D_E_wb_sel = wb; ia.D_E_rd_index = rd; ia.F_D_rs1_index = rs1; ia.F_D_rs1_used = u1;
    ia.F_D_rs2_index = rs2; ia.F_D_rs2_used = u2; ia.D_E_is_muldiv = md; ia.E_M_is_jalr = jalr;
    ia.E_M_hit = hit;
    ib.D_E_wb_sel = wb; ib.D_E_rd_index = rd; ib.F_D_rs1_index = rs1; ib.F_D_rs1_used = u1;
    ib.F_D_rs2_index = rs2; ib.F_D_rs2_used = u2; ib.D_E_is_muldiv = md; ib.E_M_is_jalr = jalr;
    ib.E_M_hit = hit;
    #1;
  endtask
  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic lu5();
    set_in(1, 5, 5, 1, 0, 0, 0, 0, 1);
  endtask
  task automatic do_reset();
    rst_n = 0;
    idle();
    tick();
    rst_n = 1;
    idle();
  endtask
  task automatic test_reset();
    rst_n = 0;
    idle();
    tick();
    tick();
    set_in(1, 5, 5, 1, 0, 0, 1, 1, 0);
    vec++; if (oa() !== O_IDLE) begin err++; $display("FAIL rst_force_a: got %b want %b", oa(), O_IDLE); end
    vec++; if (ob() !== O_IDLE) begin err++; $display("FAIL rst_force_b: got %b want %b", ob(), O_IDLE); end
    tick();
    vec++; if (ia.stall_cycle_cnt !== 16'd0) begin err++; $display("FAIL rst_stall_cnt: got %0d want 0", ia.stall_cycle_cnt); end
    vec++; if (ia.flush_cnt !== 16'd0) begin err++; $display("FAIL rst_flush_cnt: got %0d want 0", ia.flush_cnt); end
    rst_n = 1;
    idle();
    vec++; if (oa() !== O_IDLE) begin err++; $display("FAIL rst_idle_a: got %b want %b", oa(), O_IDLE); end
  endtask
  task automatic test_load_use();
    do_reset();
    lu5();
    vec++; if (oa() !== O_LU) begin err++; $display("FAIL lu1_c1: got %b want %b", oa(), O_LU); end
    vec++; if (ob() !== O_LU) begin err++; $display("FAIL lu3_c1: got %b want %b", ob(), O_LU); end
    tick();
    idle();
    vec++; if (oa() !== O_IDLE) begin err++; $display("FAIL lu1_c2: got %b want %b", oa(), O_IDLE); end
    vec++; if (ia.stall_cycle_cnt !== 16'd1) begin err++; $display("FAIL lu1_cnt: got %0d want 1", ia.stall_cycle_cnt); end
    vec++; if (ob() !== O_LU) begin err++; $display("FAIL lu3_c2: got %b want %b", ob(), O_LU); end
    tick();
    vec++; if (ob() !== O_LU) begin err++; $display("FAIL lu3_c3: got %b want %b", ob(), O_LU); end
    tick();
    vec++; if (ob() !== O_IDLE) begin err++; $display("FAIL lu3_c4: got %b want %b", ob(), O_IDLE); end
    vec++; if (ib.stall_cycle_cnt !== 4'd3) begin err++; $display("FAIL lu3_cnt: got %0d want 3", ib.stall_cycle_cnt); end
  endtask
  task automatic test_lu_redirect();
    do_reset();
    lu5();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec++; if (ob() !== O_RD) begin err++; $display("FAIL lurd_c2: got %b want %b", ob(), O_RD); end
    tick();
    idle();
    vec++; if (ob() !== O_IDLE) begin err++; $display("FAIL lurd_c3: got %b want %b", ob(), O_IDLE); end
    vec++; if (ib.flush_cnt !== 4'd1) begin err++; $display("FAIL lurd_fcnt: got %0d want 1", ib.flush_cnt); end
    vec++; if (ib.stall_cycle_cnt !== 4'd1) begin err++; $display("FAIL lurd_scnt: got %0d want 1", ib.stall_cycle_cnt); end
  endtask
  task automatic test_x0();
    do_reset();
    set_in(1, 0, 0, 1, 0, 1, 0, 0, 1);
    vec++; if (oa() !== O_IDLE) begin err++; $display("FAIL x0_a: got %b want %b", oa(), O_IDLE); end
    vec++; if (ob() !== O_IDLE) begin err++; $display("FAIL x0_b: got %b want %b", ob(), O_IDLE); end
    tick();
    set_in(1, 7, 3, 1, 7, 0, 0, 0, 1);
    vec++; if (oa() !== O_IDLE) begin err++; $display("FAIL unused_rs2_a: got %b want %b", oa(), O_IDLE); end
    vec++; if (ob() !== O_IDLE) begin err++; $display("FAIL unused_rs2_b: got %b want %b", ob(), O_IDLE); end
    set_in(1, 7, 3, 1, 7, 1, 0, 0, 1);
    vec++; if (oa() !== O_LU) begin err++; $display("FAIL used_rs2_a: got %b want %b", oa(), O_LU); end
    set_in(1, 7, 3, 1, 7, 0, 0, 0, 1);
    tick();
    vec++; if (ia.stall_cycle_cnt !== 16'd0) begin err++; $display("FAIL x0_cnt_a: got %0d want 0", ia.stall_cycle_cnt); end
    vec++; if (ib.stall_cycle_cnt !== 4'd0) begin err++; $display("FAIL x0_cnt_b: got %0d want 0", ib.stall_cycle_cnt); end
  endtask
  task automatic test_muldiv();
    do_reset();
    set_in(1, 5, 5, 1, 0, 0, 1, 0, 1);
    vec++; if (oa() !== O_MD) begin err++; $display("FAIL md4_c1: got %b want %b", oa(), O_MD); end
    vec++; if (ob() !== O_LU) begin err++; $display("FAIL md1_lu: got %b want %b", ob(), O_LU); end
    tick();
    lu5();
    vec++; if (oa() !== O_MD) begin err++; $display("FAIL md4_c2: got %b want %b", oa(), O_MD); end
    tick();
    idle();
    vec++; if (oa() !== O_MD) begin err++; $display("FAIL md4_c3: got %b want %b", oa(), O_MD); end
    tick();
    vec++; if (oa() !== O_IDLE) begin err++; $display("FAIL md4_c4: got %b want %b", oa(), O_IDLE); end
    vec++; if (ia.stall_cycle_cnt !== 16'd3) begin err++; $display("FAIL md4_cnt: got %0d want 3", ia.stall_cycle_cnt); end
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
    vec++; if (ob() !== O_IDLE) begin err++; $display("FAIL md1_none: got %b want %b", ob(), O_IDLE); end
  endtask
  task automatic test_redirect_priority();
    do_reset();
    set_in(1, 5, 5, 1, 0, 0, 0, 0, 0);
    vec++; if (oa() !== O_RD) begin err++; $display("FAIL rdlu_c1: got %b want %b", oa(), O_RD); end
    tick();
    idle();
    vec++; if (oa() !== O_IDLE) begin err++; $display("FAIL rdlu_c2: got %b want %b", oa(), O_IDLE); end
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
    vec++; if (oa() !== O_RD) begin err++; $display("FAIL jalr_md: got %b want %b", oa(), O_RD); end
    tick();
    idle();
    vec++; if (oa() !== O_IDLE) begin err++; $display("FAIL jalr_after: got %b want %b", oa(), O_IDLE); end
    vec++; if (ia.flush_cnt !== 16'd2) begin err++; $display("FAIL rd_fcnt: got %0d want 2", ia.flush_cnt); end
  endtask
  task automatic test_saturate();
    do_reset();
    lu5();
    for (int i = 0; i < 20; i++) tick();
    vec++; if (ib.stall_cycle_cnt !== 4'd15) begin err++; $display("FAIL sat_scnt_b: got %0d want 15", ib.stall_cycle_cnt); end
    vec++; if (ia.stall_cycle_cnt !== 16'd20) begin err++; $display("FAIL sat_scnt_a: got %0d want 20", ia.stall_cycle_cnt); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    vec++; if (ib.flush_cnt !== 4'd15) begin err++; $display("FAIL sat_fcnt_b: got %0d want 15", ib.flush_cnt); end
    vec++; if (ia.flush_cnt !== 16'd20) begin err++; $display("FAIL sat_fcnt_a: got %0d want 20", ia.flush_cnt); end
  endtask
  task automatic test_reset_mid_md();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    idle();
    vec++; if (oa() !== O_MD) begin err++; $display("FAIL rmd_busy: got %b want %b", oa(), O_MD); end
    rst_n = 0;
    #1;
    vec++; if (oa() !== O_IDLE) begin err++; $display("FAIL rmd_forced: got %b want %b", oa(), O_IDLE); end
    tick();
    rst_n = 1;
    #1;
    vec++; if (oa() !== O_IDLE) begin err++; $display("FAIL rmd_idle: got %b want %b", oa(), O_IDLE); end
    vec++; if (ia.stall_cycle_cnt !== 16'd0) begin err++; $display("FAIL rmd_cnt: got %0d want 0", ia.stall_cycle_cnt); end
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_lu_redirect();
    test_x0();
    test_muldiv();
    test_redirect_priority();
    test_saturate();
    test_reset_mid_md();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
